mi_sequencer: RTL and testbench

//  Micro-instruction sequencer directly downstream of the micro-instruction ROM.

---
 rtl/mi_sequencer_pkg.sv | 37 +++
 rtl/mi_sequencer_wait_timer.sv | 33 +++
 rtl/mi_sequencer.sv | 159 +++++++++++++++
 tb/tb_mi_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mi_sequencer_pkg.sv
// Shared micro-instruction definitions: MIR field positions, sequencer state
// encoding and the ROM's "undecoded" code. The micro-instruction ROM uses the
// same package so both sides agree on the field layout.
package mi_sequencer_pkg;

    localparam int MI_W    = 33;
    localparam int OPND_W  = 11;
    localparam int TIMEOUT = 15;

    // Layout: {ALU[32:29],SH[28:27],Kmx[26],MR[25],MW[24],B[23:18],C[17:12],T[11:5],A[4:0]}
    localparam int ALU_MSB  = 32;
    localparam int ALU_LSB  = 29;
    localparam int SH_MSB   = 28;
    localparam int SH_LSB   = 27;
    localparam int KMX_BIT  = 26;
    localparam int MR_BIT   = 25;
    localparam int MW_BIT   = 24;
    localparam int B_MSB    = 23;
    localparam int B_LSB    = 18;
    localparam int C_MSB    = 17;
    localparam int C_LSB    = 12;
    localparam int T_MSB    = 11;
    localparam int T_LSB    = 5;
    localparam int JUMP_BIT = 11;
    localparam int A_MSB    = 4;
    localparam int A_LSB    = 0;

    localparam logic [MI_W-1:0] MI_ILLEGAL = 33'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MEM  = 2'd2,
        WB   = 2'd3
    } mi_state_t;

endpackage

// File: rtl/mi_sequencer_wait_timer.sv
// Memory wait timer: counts MEM cycles spent without mem_ready and flags the
// cycle on which the wait limit is reached. Only instantiated by mi_sequencer
// when MI_MEM_TIMEOUT_EN is defined.
module mi_sequencer_wait_timer
    import mi_sequencer_pkg::*;
#(
    parameter int LIMIT = TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [3:0] LAST = 4'(LIMIT - 1);

    logic [3:0] count;

    // Counter restarts on MEM entry and advances once per unanswered MEM cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (clear) begin
            count <= 4'd0;
        end else if (count_en) begin
            count <= count + 4'd1;
        end
    end

    assign expired = count_en && (count == LAST);

endmodule

// File: rtl/mi_sequencer.sv
// Micro-instruction sequencer: captures a micro-instruction and its operand
// into the MIR, then walks EXEC / MEM handshake / WB while driving the
// datapath selects, memory strobes and PC jump. Optional memory timeout is
// enabled with the MI_MEM_TIMEOUT_EN macro.
module mi_sequencer
    import mi_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MI_W-1:0]   mi_in,
    input  logic [OPND_W-1:0] opnd_in,
    input  logic              mi_valid,
    output logic              mi_req,
    output logic [3:0]        alu_op,
    output logic [1:0]        sh_op,
    output logic              kmx,
    output logic [4:0]        a_sel,
    output logic [5:0]        b_sel,
    output logic [5:0]        c_sel,
    output logic              c_we,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ready,
    output logic              pc_load,
    output logic [OPND_W-1:0] pc_target,
    output logic              illegal,
    output logic              mem_err
);

    mi_state_t         state;
    logic [MI_W-1:0]   mir;
    logic [OPND_W-1:0] opnd;

    // Fields whose values are already forwarded to registered outputs at
    // capture time, plus T[5:0] reserved for the next-address sequencer.
    logic unused_mir_bits;
    assign unused_mir_bits = ^{mir[ALU_MSB:KMX_BIT], mir[B_MSB:B_LSB], mir[C_MSB:C_LSB],
                               mir[T_MSB-1:T_LSB], mir[A_MSB:A_LSB]};

    assign pc_target = opnd;

`ifdef MI_MEM_TIMEOUT_EN
    logic wait_clear;
    logic wait_en;
    logic wait_expired;
    logic mem_err_q;

    assign wait_clear = (state == EXEC);
    assign wait_en    = (state == MEM) && !mem_ready;
    assign mem_err    = mem_err_q;

    mi_sequencer_wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wait_clear),
        .count_en (wait_en),
        .expired  (wait_expired)
    );
`else
    assign mem_err = 1'b0;
`endif

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mir     <= '0;
            opnd    <= '0;
            mi_req  <= 1'b1;
            alu_op  <= 4'd0;
            sh_op   <= 2'd0;
            kmx     <= 1'b0;
            a_sel   <= 5'd0;
            b_sel   <= 6'd0;
            c_sel   <= 6'd0;
            c_we    <= 1'b0;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            pc_load <= 1'b0;
            illegal <= 1'b0;
`ifdef MI_MEM_TIMEOUT_EN
            mem_err_q <= 1'b0;
`endif
        end else begin
            illegal <= 1'b0;
            c_we    <= 1'b0;
            pc_load <= 1'b0;
`ifdef MI_MEM_TIMEOUT_EN
            mem_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (mi_valid) begin
                        if (mi_in == MI_ILLEGAL) begin
                            illegal <= 1'b1;
                        end else begin
                            mir    <= mi_in;
                            opnd   <= opnd_in;
                            state  <= EXEC;
                            mi_req <= 1'b0;
                            alu_op <= mi_in[ALU_MSB:ALU_LSB];
                            sh_op  <= mi_in[SH_MSB:SH_LSB];
                            kmx    <= mi_in[KMX_BIT];
                            a_sel  <= mi_in[A_MSB:A_LSB];
                            b_sel  <= mi_in[B_MSB:B_LSB];
                            c_sel  <= mi_in[C_MSB:C_LSB];
                        end
                    end
                end
                EXEC: begin
                    alu_op <= 4'd0;
                    sh_op  <= 2'd0;
                    kmx    <= 1'b0;
                    a_sel  <= 5'd0;
                    b_sel  <= 6'd0;
                    if (mir[MR_BIT] || mir[MW_BIT]) begin
                        state  <= MEM;
                        mem_rd <= mir[MR_BIT];
                        mem_wr <= mir[MW_BIT];
                    end else begin
                        state   <= WB;
                        c_we    <= (c_sel != 6'd0);
                        pc_load <= mir[JUMP_BIT];
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        state   <= WB;
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        c_we    <= (c_sel != 6'd0);
                        pc_load <= mir[JUMP_BIT];
                    end
`ifdef MI_MEM_TIMEOUT_EN
                    else if (wait_expired) begin
                        state     <= IDLE;
                        mem_rd    <= 1'b0;
                        mem_wr    <= 1'b0;
                        c_sel     <= 6'd0;
                        mi_req    <= 1'b1;
                        mem_err_q <= 1'b1;
                    end
`endif
                end
                WB: begin
                    state  <= IDLE;
                    c_sel  <= 6'd0;
                    mi_req <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mi_sequencer.sv
// Self-checking bench for mi_sequencer: directed scenarios plus randomized
// transactions checked against a per-phase reference of the output bundle.
// Optional timeout scenarios run when MI_MEM_TIMEOUT_EN is defined.
module tb_mi_sequencer;

    localparam int R_IDLE = 0;
    localparam int R_EXEC = 1;
    localparam int R_MEM  = 2;
    localparam int R_WB   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [32:0] mi_in;
    logic [10:0] opnd_in;
    logic        mi_valid;
    logic        mi_req;
    logic [3:0]  alu_op;
    logic [1:0]  sh_op;
    logic        kmx;
    logic [4:0]  a_sel;
    logic [5:0]  b_sel;
    logic [5:0]  c_sel;
    logic        c_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ready;
    logic        pc_load;
    logic [10:0] pc_target;
    logic        illegal;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    logic [32:0] modelMi;
    logic [10:0] modelOpnd;
    logic [63:0] rnd;
    logic [32:0] rndMi;

    logic [41:0] obs;
    assign obs = {mi_req, alu_op, sh_op, kmx, a_sel, b_sel, c_sel,
                  c_we, mem_rd, mem_wr, pc_load, pc_target, illegal, mem_err};

    mi_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mi_in     (mi_in),
        .opnd_in   (opnd_in),
        .mi_valid  (mi_valid),
        .mi_req    (mi_req),
        .alu_op    (alu_op),
        .sh_op     (sh_op),
        .kmx       (kmx),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .c_sel     (c_sel),
        .c_we      (c_we),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_ready (mem_ready),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .illegal   (illegal),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    // Expected output bundle for a phase of the current instruction, built
    // from the micro-instruction field layout.
    function automatic logic [41:0] expOut(int role, logic ill, logic err);
        logic [32:0] m;
        logic [5:0]  c;
        m = modelMi;
        c = m[17:12];
        case (role)
            R_IDLE:  return {1'b1, 4'd0, 2'd0, 1'b0, 5'd0, 6'd0, 6'd0, 4'b0000, modelOpnd, ill, err};
            R_EXEC:  return {1'b0, m[32:29], m[28:27], m[26], m[4:0], m[23:18], c, 4'b0000, modelOpnd, 2'b00};
            R_MEM:   return {1'b0, 4'd0, 2'd0, 1'b0, 5'd0, 6'd0, c, 1'b0, m[25], m[24], 1'b0, modelOpnd, 2'b00};
            R_WB:    return {1'b0, 4'd0, 2'd0, 1'b0, 5'd0, 6'd0, c, (c != 6'd0), 2'b00, m[11], modelOpnd, 2'b00};
            default: return '1;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [41:0] expected);
        total++;
        assert (obs === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [32:0] mi, input logic [10:0] op);
        mi_valid = valid;
        mi_in    = mi;
        opnd_in  = op;
    endtask

    task automatic applyNoise();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        applyStimulus(1'($urandom_range(0, 1)), r[32:0], r[42:32]);
    endtask

    // One full instruction: capture, EXEC, optional MEM with 'waits' idle
    // cycles before mem_ready, WB, then back in IDLE.
    task automatic runTxn(input string tag, input logic [32:0] mi, input logic [10:0] op,
                          input int waits, input bit noise);
        applyStimulus(1'b1, mi, op);
        @(negedge clk);
        modelMi   = mi;
        modelOpnd = op;
        mem_ready = 1'b0;
        if (noise) applyNoise(); else applyStimulus(1'b0, '0, '0);
        checkOutput({tag, "_exec"}, expOut(R_EXEC, 1'b0, 1'b0));
        if (mi[25] || mi[24]) begin
            for (int w = 0; w <= waits; w++) begin
                @(negedge clk);
                checkOutput({tag, "_mem"}, expOut(R_MEM, 1'b0, 1'b0));
                if (noise) applyNoise();
                mem_ready = (w == waits);
            end
        end
        @(negedge clk);
        applyStimulus(1'b0, '0, '0);
        mem_ready = 1'b0;
        checkOutput({tag, "_wb"}, expOut(R_WB, 1'b0, 1'b0));
        @(negedge clk);
        checkOutput({tag, "_idle"}, expOut(R_IDLE, 1'b0, 1'b0));
    endtask

    initial begin
        modelMi   = '0;
        modelOpnd = '0;
        mem_ready = 1'b0;
        applyStimulus(1'b0, '0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset_state", expOut(R_IDLE, 1'b0, 1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_reset", expOut(R_IDLE, 1'b0, 1'b0));

        // Jump micro-instruction with no memory access.
        runTxn("jump", 33'h0_008A_2800, 11'h155, 0, 1'b0);

        // Memory read held for four unanswered cycles, then answered.
        runTxn("read4", 33'h0_0200_5003, 11'h0A3, 4, 1'b0);

        // Memory ready already high on MEM entry: single MEM cycle.
        runTxn("rw0", 33'h1_0380_1C40, 11'h2F0, 0, 1'b0);

        // Undecoded ROM code: one illegal pulse, stays IDLE, operand kept.
        applyStimulus(1'b1, 33'd1, 11'h7FF);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0);
        checkOutput("illegal_pulse", expOut(R_IDLE, 1'b1, 1'b0));
        @(negedge clk);
        checkOutput("illegal_clear", expOut(R_IDLE, 1'b0, 1'b0));

        // mi_valid noise during EXEC/MEM must be ignored.
        runTxn("noise", 33'h0_0300_F0A5, 11'h011, 3, 1'b1);

        // Reset asserted while waiting in MEM.
        applyStimulus(1'b1, 33'h0_0200_3000, 11'h066);
        @(negedge clk);
        modelMi   = 33'h0_0200_3000;
        modelOpnd = 11'h066;
        applyStimulus(1'b0, '0, '0);
        checkOutput("rstmem_exec", expOut(R_EXEC, 1'b0, 1'b0));
        @(negedge clk);
        checkOutput("rstmem_mem", expOut(R_MEM, 1'b0, 1'b0));
        rst_n = 1'b0;
        @(negedge clk);
        modelMi   = '0;
        modelOpnd = '0;
        checkOutput("rstmem_reset", expOut(R_IDLE, 1'b0, 1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstmem_idle", expOut(R_IDLE, 1'b0, 1'b0));

`ifdef MI_MEM_TIMEOUT_EN
        // Write that is never answered: 15 MEM cycles then mem_err, no WB.
        applyStimulus(1'b1, 33'h0_0100_3000, 11'h1AB);
        @(negedge clk);
        modelMi   = 33'h0_0100_3000;
        modelOpnd = 11'h1AB;
        applyStimulus(1'b0, '0, '0);
        mem_ready = 1'b0;
        checkOutput("tmo_exec", expOut(R_EXEC, 1'b0, 1'b0));
        for (int w = 0; w < 15; w++) begin
            @(negedge clk);
            checkOutput("tmo_mem", expOut(R_MEM, 1'b0, 1'b0));
        end
        @(negedge clk);
        checkOutput("tmo_err", expOut(R_IDLE, 1'b0, 1'b1));
        @(negedge clk);
        checkOutput("tmo_err_clear", expOut(R_IDLE, 1'b0, 1'b0));

        // mem_ready arriving on the 15th MEM cycle wins over the timeout.
        runTxn("tmo_ready15", 33'h0_0100_3000, 11'h1AC, 14, 1'b0);
`endif

        // Randomized instructions with random wait counts and input noise.
        for (int k = 0; k < 24; k++) begin
            rnd   = {$urandom(), $urandom()};
            rndMi = rnd[32:0];
            if (rndMi == 33'd1) rndMi = 33'd2;
            runTxn("rand", rndMi, rnd[43:33], int'($urandom_range(0, 5)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
